// File: rtl/pio_in_edge_capture_if.sv
// rtl/pio_in_edge_capture_if.sv - Avalon-MM slave bus bundle for the edge-capture input PIO
interface pio_in_edge_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_edge_capture.sv
// rtl/pio_in_edge_capture.sv - synchronised input PIO with per-bit edge capture and masked IRQ
module pio_in_edge_capture #(
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = 0,
    parameter logic [31:0] RESET_MASK  = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_in_edge_capture_if.slave avs,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_mask;
    logic [2:0]       r_arm;
    logic [31:0]      r_rdata;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_armed;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_armed = (r_arm == ARM_MAX);
    assign w_wr    = avs.chipselect & ~avs.write_n;
    assign w_rise  = w_s & ~r_prev;
    assign w_fall  = ~w_s & r_prev;
    assign w_clr   = (w_wr && avs.address == 2'd3) ? avs.writedata[WIDTH-1:0] : '0;
    assign w_unused = ^avs.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_s;
        end
    end

    // Hold off edge detection until the chain and prev sample carry real input history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm <= '0;
        end else if (!w_armed) begin
            r_arm <= r_arm + 3'd1;
        end
    end

    always_comb begin
        w_sel = '0;
        if (w_armed) begin
            case (EDGE_TYPE)
                0:       w_sel = w_rise;
                1:       w_sel = w_fall;
                default: w_sel = w_rise | w_fall;
            endcase
        end
    end

    // A new edge on the same bit as a CPU clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap  <= '0;
            r_mask <= RESET_MASK[WIDTH-1:0];
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_sel;
            if (w_wr && avs.address == 2'd2) begin
                r_mask <= avs.writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs.address)
            2'd0:    w_rd_mux[WIDTH-1:0] = w_s;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_cap;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_mux;
        end
    end

    assign avs.readdata = r_rdata;
    assign irq          = |(r_cap & r_mask);
endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb/tb_pio_in_edge_capture.sv - scoreboard bench for two configurations of the edge-capture PIO
module tb_pio_in_edge_capture;
    localparam int          W_A  = 8;
    localparam int          S_A  = 2;
    localparam int          E_A  = 0;
    localparam logic [31:0] RM_A = 32'h0;
    localparam int          W_B  = 12;
    localparam int          S_B  = 3;
    localparam int          E_B  = 2;
    localparam logic [31:0] RM_B = 32'h0F0;
    localparam int          MAXC = 4096;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [W_A-1:0] in_a;
    logic [W_B-1:0] in_b;
    logic           irq_a;
    logic           irq_b;

    pio_in_edge_capture_if ifa ();
    pio_in_edge_capture_if ifb ();

    pio_in_edge_capture #(.WIDTH(W_A), .SYNC_STAGES(S_A), .EDGE_TYPE(E_A), .RESET_MASK(RM_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .avs(ifa), .in_port(in_a), .irq(irq_a)
    );
    pio_in_edge_capture #(.WIDTH(W_B), .SYNC_STAGES(S_B), .EDGE_TYPE(E_B), .RESET_MASK(RM_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .avs(ifb), .in_port(in_b), .irq(irq_b)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] samp [2][MAXC];
    int          ncyc [2];
    logic [31:0] cap [2];
    logic [31:0] msk [2];
    logic        exp_irq [2];
    logic        pend [2];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];

    function automatic int pw(int k);  return (k == 0) ? W_A : W_B; endfunction
    function automatic int ps(int k);  return (k == 0) ? S_A : S_B; endfunction
    function automatic int pe(int k);  return (k == 0) ? E_A : E_B; endfunction
    function automatic logic [31:0] wmask(int k);
        return (pw(k) >= 32) ? 32'hFFFF_FFFF : ((32'h1 << pw(k)) - 32'h1);
    endfunction

    // Synchronised value seen after edge n is the pin value sampled S-1 edges earlier.
    function automatic logic [31:0] s_after(int k, int n);
        int idx;
        idx = n - ps(k) + 1;
        if (idx < 1 || idx >= MAXC) return 32'h0;
        return samp[k][idx];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic step(input int k);
        int          n;
        logic [31:0] wm, inp, cur, prv, rise, fall, sel, clr, rd;
        logic        wr;
        wm  = wmask(k);
        inp = (k == 0) ? 32'(in_a) : 32'(in_b);
        n   = ncyc[k] + 1;
        if (n < MAXC) samp[k][n] = inp & wm;
        cur  = s_after(k, n - 1);
        prv  = s_after(k, n - 2);
        rise = cur & ~prv;
        fall = ~cur & prv;
        sel  = 32'h0;
        if (n - 1 >= ps(k) + 1)
            sel = (pe(k) == 0) ? rise : (pe(k) == 1) ? fall : (rise | fall);
        wr  = ifa.chipselect && !ifa.write_n;
        clr = (wr && ifa.address == 2'd3) ? (ifa.writedata & wm) : 32'h0;
        case (ifa.address)
            2'd0:    rd = cur;
            2'd2:    rd = msk[k];
            2'd3:    rd = cap[k];
            default: rd = 32'h0;
        endcase
        cap[k] = (cap[k] & ~clr) | sel;
        if (wr && ifa.address == 2'd2) msk[k] = ifa.writedata & wm;
        ncyc[k]    = (n < MAXC) ? n : MAXC - 1;
        exp_irq[k] = |(cap[k] & msk[k]);
        pend[k]    = ifa.chipselect && ifa.write_n;
        if (pend[k]) begin
            if (k == 0) exp_a.push_back(rd);
            else        exp_b.push_back(rd);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                ncyc[k] = 0; cap[k] = 32'h0; exp_irq[k] = 1'b0; pend[k] = 1'b0;
                msk[k] = ((k == 0) ? RM_A : RM_B) & wmask(k);
            end
            exp_a.delete();
            exp_b.delete();
        end else begin
            for (int k = 0; k < 2; k++) step(k);
        end
    end

    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        if (reset_n) begin
            chk("irq_a", 32'(irq_a), 32'(exp_irq[0]));
            chk("irq_b", 32'(irq_b), 32'(exp_irq[1]));
            if (pend[0]) begin
                if (exp_a.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_a_queue: got empty queue required an entry");
                end else begin
                    e = exp_a.pop_front();
                    chk("readdata_a", ifa.readdata, e);
                end
            end
            if (pend[1]) begin
                if (exp_b.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_b_queue: got empty queue required an entry");
                end else begin
                    e = exp_b.pop_front();
                    chk("readdata_b", ifb.readdata, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
        ifa.chipselect = cs; ifa.write_n = wn; ifa.address = a; ifa.writedata = d;
        ifb.chipselect = cs; ifb.write_n = wn; ifb.address = a; ifb.writedata = d;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d); cyc(1); bus(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b1, 1'b1, a, 32'h0); cyc(1); bus(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    initial begin
        in_a = 8'hFF;
        in_b = 12'hFFF;
        bus(1'b0, 1'b1, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq_a", 32'(irq_a), 32'h0);
        chk("rst_irq_b", 32'(irq_b), 32'h0);
        chk("rst_rd_a", ifa.readdata, 32'h0);
        chk("rst_rd_b", ifb.readdata, 32'h0);
        reset_n = 1'b1;
        cyc(10);
        rd(2'd0); chk("hi_at_reset_data", ifa.readdata, 32'h0000_00FF);
        rd(2'd3); chk("hi_at_reset_cap", ifa.readdata, 32'h0);

        in_a = 8'h00; in_b = 12'h000; cyc(6);
        wr(2'd2, 32'h1);
        in_a = 8'h01; cyc(4);
        chk("rise_irq_a", 32'(irq_a), 32'h1);
        rd(2'd3); chk("rise_cap_a", ifa.readdata, 32'h1);
        wr(2'd3, 32'h1); chk("clr_irq_a", 32'(irq_a), 32'h0);
        rd(2'd3); chk("clr_cap_a", ifa.readdata, 32'h0);

        in_a = 8'h00; cyc(4);
        in_a = 8'h01; cyc(5);
        in_a = 8'h00; cyc(4);
        in_a = 8'h01; cyc(2);
        wr(2'd3, 32'h1); chk("set_wins_irq", 32'(irq_a), 32'h1);
        rd(2'd3); chk("set_wins_cap", ifa.readdata, 32'h1);

        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF);
        cyc(6);
        in_b = 12'h008; cyc(4);
        in_b = 12'h000; cyc(6);
        rd(2'd3); chk("any_edge_cap_b", ifb.readdata, 32'h8);
        chk("any_edge_noirq_b", 32'(irq_b), 32'h0);
        wr(2'd2, 32'h8); chk("mask_irq_b", 32'(irq_b), 32'h1);

        in_b = 12'hABC; cyc(6);
        rd(2'd1); chk("rsvd_b", ifb.readdata, 32'h0);
        rd(2'd0); chk("data_b", ifb.readdata, 32'h0000_0ABC);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2); chk("mask_ext_b", ifb.readdata, 32'h0000_0FFF);
        chk("mask_ext_a", ifa.readdata, 32'h0000_00FF);

        for (int i = 0; i < 400; i++) begin
            int r;
            if ($urandom_range(0, 3) == 0) in_a = W_A'($urandom);
            if ($urandom_range(0, 3) == 0) in_b = W_B'($urandom);
            r = $urandom_range(0, 3);
            if (r == 1)      bus(1'b1, 1'b1, 2'($urandom), 32'h0);
            else if (r == 2) bus(1'b1, 1'b0, 2'($urandom), $urandom);
            else             bus(1'b0, 1'b1, 2'($urandom), $urandom);
            cyc(1);
        end
        bus(1'b0, 1'b1, 2'd0, 32'h0);

        wr(2'd2, 32'hFF);
        in_a = 8'h00; cyc(5);
        in_a = 8'h80; cyc(5);
        chk("pre_rst_irq_a", 32'(irq_a), 32'h1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_irq_a", 32'(irq_a), 32'h0);
        chk("async_rst_irq_b", 32'(irq_b), 32'h0);
        chk("async_rst_rd_a", ifa.readdata, 32'h0);
        chk("async_rst_rd_b", ifb.readdata, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(2);
        rd(2'd2);
        chk("rst_mask_a", ifa.readdata, RM_A);
        chk("rst_mask_b", ifb.readdata, RM_B);
        rd(2'd3);
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
